// File: rtl/clock_speed_ctrl.sv
// Divides the PLL clock into four logic clocks, debounces the speed switches and
// hands cpuclk between clocks without runt pulses (hold low, then align to new clock low).
module clock_speed_ctrl #(
  parameter int unsigned HALF_2M  = 25,
  parameter int unsigned HALF_1M  = 50,
  parameter int unsigned HALF_31K = 1600,
  parameter int unsigned HALF_250 = 200000,
  parameter int unsigned DEBOUNCE = 1000000,
  parameter int unsigned GAP      = 8
) (
  input  logic       pll0_100MHz,
  input  logic       reset,
  input  logic [1:0] sw,
  output logic       cpuclk,
  output logic [1:0] active_sel,
  output logic       switching
);

  localparam int unsigned HALF_A   = (HALF_2M > HALF_1M) ? HALF_2M : HALF_1M;
  localparam int unsigned HALF_B   = (HALF_31K > HALF_250) ? HALF_31K : HALF_250;
  localparam int unsigned HALF_MAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int unsigned DIV_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int unsigned DB_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  // Indexed by switch code: 00=250Hz, 01=1MHz, 10=31.25kHz, 11=2MHz
  localparam int unsigned HALF_TBL [4] = '{HALF_250, HALF_1M, HALF_31K, HALF_2M};

  typedef enum logic [1:0] {ST_RUN, ST_WAIT_LOW, ST_GAP, ST_ALIGN} state_e;

  logic [DIV_W-1:0] div_cnt_q [4];
  logic [DIV_W-1:0] div_cnt_d [4];
  logic [3:0]       gclk_q, gclk_d;
  logic [1:0]       sync1_q, sync1_d, sw_s_q, sw_s_d;
  logic [1:0]       cand_q, cand_d, stable_q, stable_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  state_e           state_q, state_d;
  logic [1:0]       tgt_q, tgt_d, active_sel_q, active_sel_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             cpuclk_q, cpuclk_d, switching_q, switching_d;

  // Free-running dividers; they keep counting through speed changes
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      div_cnt_d[i] = div_cnt_q[i] + DIV_W'(1);
      gclk_d[i]    = gclk_q[i];
      if (div_cnt_q[i] == DIV_W'(HALF_TBL[i] - 1)) begin
        div_cnt_d[i] = '0;
        gclk_d[i]    = ~gclk_q[i];
      end
    end
  end

  // Two-flop synchronizer followed by a restart-on-change debounce counter
  always_comb begin
    sync1_d  = sw;
    sw_s_d   = sync1_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (sw_s_q != cand_q) begin
      cand_d   = sw_s_q;
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
      stable_d = cand_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge pll0_100MHz) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (stable_q != active_sel_q)     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!gclk_q[active_sel_q])        state_d = ST_GAP;
      ST_GAP:      if (gap_cnt_q == GAP_W'(GAP - 1)) state_d = ST_ALIGN;
      ST_ALIGN:    if (!gclk_q[tgt_q])               state_d = ST_RUN;
      default:                                       state_d = ST_RUN;
    endcase
  end

  // cpuclk tracks the active clock only in RUN/WAIT_LOW; it is forced low otherwise
  always_comb begin
    cpuclk_d     = 1'b0;
    active_sel_d = active_sel_q;
    tgt_d        = tgt_q;
    gap_cnt_d    = gap_cnt_q;
    switching_d  = (state_d != ST_RUN);
    case (state_q)
      ST_RUN: begin
        cpuclk_d = gclk_q[active_sel_q];
        if (stable_q != active_sel_q) tgt_d = stable_q;
      end
      ST_WAIT_LOW: begin
        cpuclk_d  = gclk_q[active_sel_q];
        gap_cnt_d = '0;
      end
      ST_GAP:   gap_cnt_d = gap_cnt_q + GAP_W'(1);
      ST_ALIGN: if (!gclk_q[tgt_q]) active_sel_d = tgt_q;
      default:  cpuclk_d = 1'b0;
    endcase
  end

  always_ff @(posedge pll0_100MHz) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) div_cnt_q[i] <= '0;
      gclk_q       <= '0;
      sync1_q      <= '0;
      sw_s_q       <= '0;
      cand_q       <= '0;
      stable_q     <= '0;
      db_cnt_q     <= '0;
      tgt_q        <= '0;
      active_sel_q <= '0;
      gap_cnt_q    <= '0;
      cpuclk_q     <= 1'b0;
      switching_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) div_cnt_q[i] <= div_cnt_d[i];
      gclk_q       <= gclk_d;
      sync1_q      <= sync1_d;
      sw_s_q       <= sw_s_d;
      cand_q       <= cand_d;
      stable_q     <= stable_d;
      db_cnt_q     <= db_cnt_d;
      tgt_q        <= tgt_d;
      active_sel_q <= active_sel_d;
      gap_cnt_q    <= gap_cnt_d;
      cpuclk_q     <= cpuclk_d;
      switching_q  <= switching_d;
    end
  end

  assign cpuclk     = cpuclk_q;
  assign active_sel = active_sel_q;
  assign switching  = switching_q;

endmodule
